// File: rtl/mfb_meta_extractor_buf.sv
// Extracts per-frame metadata from an MFB stream into an MVB FIFO, optionally
// passing the MFB stream through unchanged.
module mfb_meta_extractor_buf #(
  parameter int MFB_REGIONS        = 2,
  parameter int MFB_REGION_SIZE    = 1,
  parameter int MFB_BLOCK_SIZE     = 8,
  parameter int MFB_ITEM_WIDTH     = 32,
  parameter int MFB_META_WIDTH     = 2,
  parameter int MFB_META_ALIGNMENT = 1,
  parameter int EXTRACT_MODE       = 1,
  parameter int FIFO_DEPTH         = 16,
  localparam int DATA_W    = MFB_REGIONS*MFB_REGION_SIZE*MFB_BLOCK_SIZE*MFB_ITEM_WIDTH,
  localparam int META_W    = MFB_REGIONS*MFB_META_WIDTH,
  localparam int SOF_POS_W = MFB_REGIONS*((MFB_REGION_SIZE > 1) ? $clog2(MFB_REGION_SIZE) : 1),
  localparam int EOF_POS_W = MFB_REGIONS*((MFB_REGION_SIZE*MFB_BLOCK_SIZE > 1) ?
                                          $clog2(MFB_REGION_SIZE*MFB_BLOCK_SIZE) : 1)
) (
  input  logic                   CLK,
  input  logic                   RESET,

  input  logic [DATA_W-1:0]      RX_MFB_DATA,
  input  logic [META_W-1:0]      RX_MFB_META,
  input  logic [MFB_REGIONS-1:0] RX_MFB_SOF,
  input  logic [MFB_REGIONS-1:0] RX_MFB_EOF,
  input  logic [SOF_POS_W-1:0]   RX_MFB_SOF_POS,
  input  logic [EOF_POS_W-1:0]   RX_MFB_EOF_POS,
  input  logic                   RX_MFB_SRC_RDY,
  output logic                   RX_MFB_DST_RDY,

  output logic [DATA_W-1:0]      TX_MFB_DATA,
  output logic [META_W-1:0]      TX_MFB_META,
  output logic [MFB_REGIONS-1:0] TX_MFB_SOF,
  output logic [MFB_REGIONS-1:0] TX_MFB_EOF,
  output logic [SOF_POS_W-1:0]   TX_MFB_SOF_POS,
  output logic [EOF_POS_W-1:0]   TX_MFB_EOF_POS,
  output logic                   TX_MFB_SRC_RDY,
  input  logic                   TX_MFB_DST_RDY,

  output logic [META_W-1:0]      TX_MVB_DATA,
  output logic [MFB_REGIONS-1:0] TX_MVB_VLD,
  output logic                   TX_MVB_SRC_RDY,
  input  logic                   TX_MVB_DST_RDY,

  input  logic                   CNT_CLR,
  output logic [31:0]            CNT_PKTS
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PC_W  = $clog2(MFB_REGIONS + 1);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(FIFO_DEPTH);

  logic [META_W-1:0]      mem_data [FIFO_DEPTH];
  logic [MFB_REGIONS-1:0] mem_vld  [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         occ;
  logic [31:0]            cnt_q;

  logic                   fifo_full, fifo_empty;
  logic [MFB_REGIONS-1:0] sel;
  logic                   push, pop;
  logic [PC_W-1:0]        pc;
  logic [32:0]            cnt_sum;

  assign fifo_full  = (occ == FULL_OCC);
  assign fifo_empty = (occ == '0);
  assign sel        = (MFB_META_ALIGNMENT == 0) ? RX_MFB_SOF : RX_MFB_EOF;

  // Both ports use valid/ready: a transfer happens on a CLK edge where SRC_RDY
  // and DST_RDY are both 1; SRC_RDY never waits on DST_RDY.
  assign RX_MFB_DST_RDY = !fifo_full && (TX_MFB_DST_RDY || (EXTRACT_MODE == 0));
  assign push = RX_MFB_SRC_RDY && RX_MFB_DST_RDY && (|sel);
  assign pop  = !fifo_empty && TX_MVB_DST_RDY;

  assign TX_MFB_DATA    = RX_MFB_DATA;
  assign TX_MFB_META    = RX_MFB_META;
  assign TX_MFB_SOF     = RX_MFB_SOF;
  assign TX_MFB_EOF     = RX_MFB_EOF;
  assign TX_MFB_SOF_POS = RX_MFB_SOF_POS;
  assign TX_MFB_EOF_POS = RX_MFB_EOF_POS;
  assign TX_MFB_SRC_RDY = (EXTRACT_MODE != 0) ? (RX_MFB_SRC_RDY && !fifo_full) : 1'b0;

  // First-word-fall-through: the head entry is always presented; VLD is forced
  // low while empty so a freshly reset block shows no stale items.
  assign TX_MVB_SRC_RDY = !fifo_empty;
  assign TX_MVB_DATA    = mem_data[rd_ptr];
  assign TX_MVB_VLD     = fifo_empty ? '0 : mem_vld[rd_ptr];
  assign CNT_PKTS       = cnt_q;

  always_comb begin
    pc = '0;
    for (int i = 0; i < MFB_REGIONS; i++) pc = pc + PC_W'(sel[i]);
  end

  assign cnt_sum = {1'b0, cnt_q} + 33'(pc);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wr_ptr] <= RX_MFB_META;
      mem_vld[wr_ptr]  <= sel;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
      if (CNT_CLR)          cnt_q <= '0;
      else if (push)        cnt_q <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
  end

endmodule

// File: tb/tb_mfb_meta_extractor_buf.sv
// Bench for mfb_meta_extractor_buf: EOF-aligned pass-through instance (a) and
// SOF-aligned metadata-only instance (b) driven by shared RX stimulus.
module tb_mfb_meta_extractor_buf;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] rx_data;
  logic [3:0]   rx_meta;
  logic [1:0]   rx_sof, rx_eof, rx_sof_pos;
  logic [5:0]   rx_eof_pos;
  logic         rx_src_rdy, tx_mfb_dst_rdy, a_mvb_dst_rdy, b_mvb_dst_rdy, cnt_clr;

  logic         a_rx_dst_rdy, a_tx_src_rdy, a_mvb_src_rdy;
  logic [511:0] a_tx_data;
  logic [3:0]   a_tx_meta, a_mvb_data;
  logic [1:0]   a_tx_sof, a_tx_eof, a_tx_sof_pos, a_mvb_vld;
  logic [5:0]   a_tx_eof_pos;
  logic [31:0]  a_cnt;

  logic         b_rx_dst_rdy, b_tx_src_rdy, b_mvb_src_rdy;
  logic [511:0] b_tx_data;
  logic [3:0]   b_tx_meta, b_mvb_data;
  logic [1:0]   b_tx_sof, b_tx_eof, b_tx_sof_pos, b_mvb_vld;
  logic [5:0]   b_tx_eof_pos;
  logic [31:0]  b_cnt;

  always #5 clk = ~clk;

  mfb_meta_extractor_buf dut_a (
    .CLK(clk), .RESET(rst),
    .RX_MFB_DATA(rx_data), .RX_MFB_META(rx_meta), .RX_MFB_SOF(rx_sof), .RX_MFB_EOF(rx_eof),
    .RX_MFB_SOF_POS(rx_sof_pos), .RX_MFB_EOF_POS(rx_eof_pos),
    .RX_MFB_SRC_RDY(rx_src_rdy), .RX_MFB_DST_RDY(a_rx_dst_rdy),
    .TX_MFB_DATA(a_tx_data), .TX_MFB_META(a_tx_meta), .TX_MFB_SOF(a_tx_sof), .TX_MFB_EOF(a_tx_eof),
    .TX_MFB_SOF_POS(a_tx_sof_pos), .TX_MFB_EOF_POS(a_tx_eof_pos),
    .TX_MFB_SRC_RDY(a_tx_src_rdy), .TX_MFB_DST_RDY(tx_mfb_dst_rdy),
    .TX_MVB_DATA(a_mvb_data), .TX_MVB_VLD(a_mvb_vld),
    .TX_MVB_SRC_RDY(a_mvb_src_rdy), .TX_MVB_DST_RDY(a_mvb_dst_rdy),
    .CNT_CLR(cnt_clr), .CNT_PKTS(a_cnt)
  );

  mfb_meta_extractor_buf #(.MFB_META_ALIGNMENT(0), .EXTRACT_MODE(0)) dut_b (
    .CLK(clk), .RESET(rst),
    .RX_MFB_DATA(rx_data), .RX_MFB_META(rx_meta), .RX_MFB_SOF(rx_sof), .RX_MFB_EOF(rx_eof),
    .RX_MFB_SOF_POS(rx_sof_pos), .RX_MFB_EOF_POS(rx_eof_pos),
    .RX_MFB_SRC_RDY(rx_src_rdy), .RX_MFB_DST_RDY(b_rx_dst_rdy),
    .TX_MFB_DATA(b_tx_data), .TX_MFB_META(b_tx_meta), .TX_MFB_SOF(b_tx_sof), .TX_MFB_EOF(b_tx_eof),
    .TX_MFB_SOF_POS(b_tx_sof_pos), .TX_MFB_EOF_POS(b_tx_eof_pos),
    .TX_MFB_SRC_RDY(b_tx_src_rdy), .TX_MFB_DST_RDY(tx_mfb_dst_rdy),
    .TX_MVB_DATA(b_mvb_data), .TX_MVB_VLD(b_mvb_vld),
    .TX_MVB_SRC_RDY(b_mvb_src_rdy), .TX_MVB_DST_RDY(b_mvb_dst_rdy),
    .CNT_CLR(cnt_clr), .CNT_PKTS(b_cnt)
  );

  int tests = 0;
  int failures = 0;
  logic check_en = 1'b0;
  logic frame_chk_en = 1'b0;

  // Scoreboard: each entry is {vld[1:0], data[3:0]} in push order.
  logic [5:0] exp_a_q[$];
  logic [5:0] exp_b_q[$];
  logic [1:0] frame_q[$];
  longint exp_a_cnt = 0;
  longint exp_b_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs follow from the queue contents; on each edge apply the
  // transfer rules to the inputs that will be sampled there.
  always @(negedge clk) begin
    logic a_full, b_full, a_push, b_push, a_pop, b_pop;
    logic [5:0] itm;
    a_full = (exp_a_q.size() == 16);
    b_full = (exp_b_q.size() == 16);
    if (check_en) begin
      chk("a_rx_dst_rdy", 64'(a_rx_dst_rdy), 64'(!a_full && tx_mfb_dst_rdy));
      chk("a_tx_src_rdy", 64'(a_tx_src_rdy), 64'(rx_src_rdy && !a_full));
      chk("a_tx_mfb_ctl", {a_tx_meta, a_tx_sof, a_tx_eof, a_tx_sof_pos, a_tx_eof_pos},
          {rx_meta, rx_sof, rx_eof, rx_sof_pos, rx_eof_pos});
      chk("a_tx_data_diff", 64'(a_tx_data !== rx_data), 64'(0));
      chk("a_mvb_src_rdy", 64'(a_mvb_src_rdy), 64'(exp_a_q.size() != 0));
      if (exp_a_q.size() != 0) chk("a_mvb_item", 64'({a_mvb_vld, a_mvb_data}), 64'(exp_a_q[0]));
      chk("a_cnt", 64'(a_cnt), 64'(exp_a_cnt));
      chk("b_rx_dst_rdy", 64'(b_rx_dst_rdy), 64'(!b_full));
      chk("b_tx_src_rdy", 64'(b_tx_src_rdy), 64'(0));
      chk("b_mvb_src_rdy", 64'(b_mvb_src_rdy), 64'(exp_b_q.size() != 0));
      if (exp_b_q.size() != 0) chk("b_mvb_item", 64'({b_mvb_vld, b_mvb_data}), 64'(exp_b_q[0]));
      chk("b_cnt", 64'(b_cnt), 64'(exp_b_cnt));
    end
    if (rst) begin
      exp_a_q.delete();
      exp_b_q.delete();
      exp_a_cnt = 0;
      exp_b_cnt = 0;
    end else begin
      a_push = rx_src_rdy && !a_full && tx_mfb_dst_rdy && (|rx_eof);
      b_push = rx_src_rdy && !b_full && (|rx_sof);
      a_pop  = (exp_a_q.size() != 0) && a_mvb_dst_rdy;
      b_pop  = (exp_b_q.size() != 0) && b_mvb_dst_rdy;
      if (a_pop) begin
        itm = exp_a_q.pop_front();
        if (frame_chk_en) begin
          for (int r = 0; r < 2; r++) begin
            if (a_mvb_vld[r]) begin
              if (frame_q.size() == 0) chk("frame_order_extra", 64'(a_mvb_data[2*r +: 2]), 64'hDEAD);
              else chk("frame_order", 64'(a_mvb_data[2*r +: 2]), 64'(frame_q.pop_front()));
            end
          end
        end
      end
      if (b_pop) itm = exp_b_q.pop_front();
      if (a_push) exp_a_q.push_back({rx_eof, rx_meta});
      if (b_push) exp_b_q.push_back({rx_sof, rx_meta});
      if (cnt_clr) exp_a_cnt = 0;
      else if (a_push) exp_a_cnt = (exp_a_cnt + $countones(rx_eof) > 64'hFFFF_FFFF) ?
                                   64'hFFFF_FFFF : exp_a_cnt + $countones(rx_eof);
      if (cnt_clr) exp_b_cnt = 0;
      else if (b_push) exp_b_cnt = (exp_b_cnt + $countones(rx_sof) > 64'hFFFF_FFFF) ?
                                   64'hFFFF_FFFF : exp_b_cnt + $countones(rx_sof);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic src, input logic [1:0] sof, input logic [1:0] eof,
                          input logic [3:0] meta);
    rx_src_rdy = src;
    rx_sof     = sof;
    rx_eof     = eof;
    rx_meta    = meta;
    for (int k = 0; k < 16; k++) rx_data[32*k +: 32] = $urandom;
    rx_sof_pos = 2'($urandom_range(0, 3));
    rx_eof_pos = 6'($urandom_range(0, 63));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    a_mvb_dst_rdy = 1'b1;
    b_mvb_dst_rdy = 1'b1;
    rx_src_rdy    = 1'b0;
    @(negedge clk);
    while ((a_mvb_src_rdy || b_mvb_src_rdy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= budget) begin
      failures++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required empty", n);
    end
  endtask

  initial begin
    int frames_started, frames_done, rem, len, cyc;
    logic [1:0] sof, eof, eof_meta_lo, eof_meta_hi;
    logic [3:0] meta;
    logic acc;
    tx_mfb_dst_rdy = 1'b1;
    a_mvb_dst_rdy  = 1'b1;
    b_mvb_dst_rdy  = 1'b1;
    cnt_clr        = 1'b0;
    set_word(1'b0, 2'b00, 2'b00, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_en = 1'b1;

    // Post-reset state
    @(negedge clk);
    chk("rst_a_src_rdy", 64'(a_mvb_src_rdy), 64'(0));
    chk("rst_a_vld", 64'(a_mvb_vld), 64'(0));
    chk("rst_a_cnt", 64'(a_cnt), 64'(0));
    chk("rst_a_dst_rdy", 64'(a_rx_dst_rdy), 64'(1));
    chk("rst_b_dst_rdy", 64'(b_rx_dst_rdy), 64'(1));
    chk("rst_b_vld", 64'(b_mvb_vld), 64'(0));

    // SOF in region 0, EOF in region 1, META = 0b10_01
    step();
    a_mvb_dst_rdy = 1'b0;
    b_mvb_dst_rdy = 1'b0;
    set_word(1'b1, 2'b01, 2'b10, 4'b1001);
    @(negedge clk);
    chk("align_b_not_yet", 64'(b_mvb_src_rdy), 64'(0));
    step();
    set_word(1'b0, 2'b00, 2'b00, 4'h0);
    @(negedge clk);
    chk("align_b_src_rdy", 64'(b_mvb_src_rdy), 64'(1));
    chk("align_b_vld", 64'(b_mvb_vld), 64'b01);
    chk("align_b_item0", 64'(b_mvb_data[1:0]), 64'b01);
    chk("align_a_vld", 64'(a_mvb_vld), 64'b10);
    chk("align_a_item1", 64'(a_mvb_data[3:2]), 64'b10);
    chk("align_a_cnt", 64'(a_cnt), 64'(1));
    chk("align_b_cnt", 64'(b_cnt), 64'(1));
    drain(10);

    // Fill to 16 with MVB stalled, then pop once, then push+pop at 15 across the wrap
    step();
    a_mvb_dst_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_word(1'b1, 2'b00, 2'b01, 4'(i));
      step();
    end
    set_word(1'b1, 2'b00, 2'b01, 4'hA);
    @(negedge clk);
    chk("full_dst_rdy", 64'(a_rx_dst_rdy), 64'(0));
    chk("full_cnt", 64'(a_cnt), 64'(17));
    repeat (3) step();
    a_mvb_dst_rdy = 1'b1;
    step();
    @(negedge clk);
    chk("pop_restores_dst_rdy", 64'(a_rx_dst_rdy), 64'(1));
    for (int j = 0; j < 6; j++) begin
      step();
      set_word(1'b1, 2'b00, 2'b01, 4'(j + 5));
    end
    @(negedge clk);
    chk("occ15_dst_rdy", 64'(a_rx_dst_rdy), 64'(1));
    drain(64);

    // Counter clear wins over a same-cycle 2-item write
    step();
    set_word(1'b1, 2'b11, 2'b11, 4'b0110);
    cnt_clr = 1'b1;
    step();
    set_word(1'b0, 2'b00, 2'b00, 4'h0);
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_a_cnt", 64'(a_cnt), 64'(0));
    chk("clr_b_cnt", 64'(b_cnt), 64'(0));
    chk("clr_a_vld", 64'(a_mvb_vld), 64'b11);
    drain(10);

    // Reset with 5 entries buffered and a frame in flight
    step();
    a_mvb_dst_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_word(1'b1, 2'b01, 2'b01, 4'(k + 3));
      step();
    end
    rst = 1'b1;
    set_word(1'b1, 2'b01, 2'b00, 4'h7);
    @(negedge clk);
    chk("pre_rst_cnt", 64'(a_cnt), 64'(5));
    step();
    rst = 1'b0;
    set_word(1'b0, 2'b00, 2'b00, 4'h0);
    @(negedge clk);
    chk("mid_rst_src_rdy", 64'(a_mvb_src_rdy), 64'(0));
    chk("mid_rst_cnt", 64'(a_cnt), 64'(0));
    chk("mid_rst_vld", 64'(a_mvb_vld), 64'(0));

    // 2000 frames of 60..512 B (32 B per region) with random back-pressure
    step();
    frame_chk_en   = 1'b1;
    frames_started = 0;
    frames_done    = 0;
    rem            = 0;
    cyc            = 0;
    while ((frames_started < 2000 || rem != 0) && cyc < 60000) begin
      sof = 2'b00;
      eof = 2'b00;
      meta = 4'($urandom_range(0, 15));
      for (int r = 0; r < 2; r++) begin
        if (rem == 0 && frames_started < 2000) begin
          len = $urandom_range(60, 512);
          rem = (len + 31) / 32;
          sof[r] = 1'b1;
          frames_started++;
        end
        if (rem > 0) begin
          rem--;
          if (rem == 0) eof[r] = 1'b1;
        end
      end
      eof_meta_lo = meta[1:0];
      eof_meta_hi = meta[3:2];
      set_word(1'b0, sof, eof, meta);
      acc = 1'b0;
      while (!acc && cyc < 60000) begin
        rx_src_rdy     = ($urandom_range(0, 3) != 0);
        tx_mfb_dst_rdy = ($urandom_range(0, 3) != 0);
        a_mvb_dst_rdy  = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        acc = rx_src_rdy && a_rx_dst_rdy;
        if (acc) begin
          if (eof[0]) begin frame_q.push_back(eof_meta_lo); frames_done++; end
          if (eof[1]) begin frame_q.push_back(eof_meta_hi); frames_done++; end
        end
        step();
        cyc++;
      end
    end
    tests++;
    if (cyc >= 60000) begin
      failures++;
      $display("FAIL stream_timeout: %0d frames done, required 2000", frames_done);
    end
    tx_mfb_dst_rdy = 1'b1;
    drain(100);
    @(negedge clk);
    chk("stream_cnt", 64'(a_cnt), 64'(2000));
    chk("stream_frames_left", 64'(frame_q.size()), 64'(0));
    chk("stream_frames_done", 64'(frames_done), 64'(2000));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
